// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add multiplier for the EX-stage MUL.
// Produces the low WIDTH bits of data1_i * data2_i, stalling the pipeline
// while the iterations run, and presents the product with done_o for as
// long as the retiring MUL is held in EX.
module mul_sequencer #(
    parameter int              WIDTH    = 32,
    parameter logic [2:0]      MUL_CODE = 3'b100,
    parameter int              CNT_W    = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             hold_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Last iteration index: a full-width multiplier needs WIDTH iterations.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;

    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] mcand_nxt_s;
    logic [WIDTH-1:0] mplier_nxt_s;
    logic [WIDTH-1:0] acc_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic             req_s;
    logic [WIDTH-1:0] mplier_shift_s;

    assign req_s          = valid_i && (ALUCtrl_i == MUL_CODE);
    assign mplier_shift_s = mplier_r >> 1;

    // Next-state and datapath update for one multiply iteration.
    always_comb begin
        state_nxt_s  = state_r;
        mcand_nxt_s  = mcand_r;
        mplier_nxt_s = mplier_r;
        acc_nxt_s    = acc_r;
        cnt_nxt_s    = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    mcand_nxt_s  = data1_i;
                    mplier_nxt_s = data2_i;
                    acc_nxt_s    = {WIDTH{1'b0}};
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    state_nxt_s  = BUSY;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            BUSY: begin
                if (mplier_r[0]) begin
                    acc_nxt_s = acc_r + mcand_r;
                end else begin
                    acc_nxt_s = acc_r;
                end
                mcand_nxt_s  = mcand_r << 1;
                mplier_nxt_s = mplier_shift_s;
                cnt_nxt_s    = cnt_r + CNT_ONE;
                // Stop early once no multiplier bits remain.
                if ((mplier_shift_s == {WIDTH{1'b0}}) || (cnt_r == CNT_LAST)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                // The retiring MUL still shows MUL_CODE, so req is not looked at here.
                if (hold_i) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            mcand_r  <= mcand_nxt_s;
            mplier_r <= mplier_nxt_s;
            acc_r    <= acc_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    // Stall covers the request cycle and every iteration; reset forces it low.
    always_comb begin
        if (rst_i) begin
            stall_o = 1'b0;
            done_o  = 1'b0;
        end else begin
            stall_o = ((state_r == IDLE) && req_s) || (state_r == BUSY);
            done_o  = (state_r == DONE);
        end
    end

    assign result_o = acc_r;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed testbench for mul_sequencer with hand-computed expectations.
module tb_mul_sequencer;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic [2:0]  ALUCtrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        hold_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int errors_r;
    int checks_r;

    mul_sequencer #(
        .WIDTH    (32),
        .MUL_CODE (3'b100),
        .CNT_W    (5)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .hold_i    (hold_i),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .result_o  (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_r++;
        if (obs !== exp_v) begin
            errors_r++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock, drive inputs just after the edge, then settle.
    task automatic apply(input logic [31:0] a, input logic [31:0] b,
                         input logic v, input logic [2:0] code, input logic h);
        @(posedge clk_i);
        #1;
        data1_i   = a;
        data2_i   = b;
        valid_i   = v;
        ALUCtrl_i = code;
        hold_i    = h;
        #1;
    endtask

    // Count consecutive stall cycles starting with the current one (bounded).
    task automatic count_stall(output int n);
        n = 0;
        while (stall_o && n < 40) begin
            n++;
            @(posedge clk_i);
            #2;
        end
    endtask

    int n;

    initial begin
        errors_r  = 0;
        checks_r  = 0;
        rst_i     = 1'b1;
        valid_i   = 1'b1;
        ALUCtrl_i = 3'b100;
        data1_i   = 32'd3;
        data2_i   = 32'd3;
        hold_i    = 1'b0;

        // Reset: outputs forced low even with a MUL request present.
        @(posedge clk_i);
        #2;
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        valid_i = 1'b0;
        #1;
        check("rst_result", result_o, 32'd0);
        check("rst_idle_stall", {31'd0, stall_o}, 32'd0);

        // 7 x 6: k=2 -> 4 stall cycles.
        apply(32'd7, 32'd6, 1'b1, 3'b100, 1'b0);
        count_stall(n);
        check("m7x6_stall", n, 32'd4);
        check("m7x6_done", {31'd0, done_o}, 32'd1);
        check("m7x6_result", result_o, 32'd42);
        apply(32'd0, 32'd0, 1'b0, 3'b000, 1'b0);
        check("m7x6_idle_done", {31'd0, done_o}, 32'd0);
        check("m7x6_hold_result", result_o, 32'd42);

        // All-ones squared: full 32 iterations, 33 stall cycles.
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'b100, 1'b0);
        count_stall(n);
        check("max_stall", n, 32'd33);
        check("max_done", {31'd0, done_o}, 32'd1);
        check("max_result", result_o, 32'd1);
        apply(32'd0, 32'd0, 1'b0, 3'b000, 1'b0);

        // Multiply by zero: minimum 2-cycle stall.
        apply(32'h1234_5678, 32'd0, 1'b1, 3'b100, 1'b0);
        count_stall(n);
        check("zero_stall", n, 32'd2);
        check("zero_done", {31'd0, done_o}, 32'd1);
        check("zero_result", result_o, 32'd0);
        apply(32'd0, 32'd0, 1'b0, 3'b000, 1'b0);

        // Hold in DONE: request stays high, no restart, result stable.
        apply(32'd5, 32'd3, 1'b1, 3'b100, 1'b1);
        count_stall(n);
        check("hold_stall", n, 32'd3);
        check("hold_done1", {31'd0, done_o}, 32'd1);
        check("hold_result1", result_o, 32'd15);
        @(posedge clk_i);
        #2;
        check("hold_done2", {31'd0, done_o}, 32'd1);
        check("hold_stall2", {31'd0, stall_o}, 32'd0);
        check("hold_result2", result_o, 32'd15);
        apply(32'd0, 32'd0, 1'b0, 3'b000, 1'b0);
        check("hold_done3", {31'd0, done_o}, 32'd1);
        check("hold_result3", result_o, 32'd15);
        apply(32'd0, 32'd0, 1'b0, 3'b000, 1'b0);
        check("hold_release_done", {31'd0, done_o}, 32'd0);
        check("hold_release_stall", {31'd0, stall_o}, 32'd0);

        // Back-to-back: second MUL starts the cycle after DONE.
        apply(32'd3, 32'd3, 1'b1, 3'b100, 1'b0);
        count_stall(n);
        check("b2b_first_stall", n, 32'd3);
        check("b2b_first_done", {31'd0, done_o}, 32'd1);
        check("b2b_first_result", result_o, 32'd9);
        apply(32'd2, 32'd4, 1'b1, 3'b100, 1'b0);
        check("b2b_second_start", {31'd0, stall_o}, 32'd1);
        count_stall(n);
        check("b2b_second_stall", n, 32'd4);
        check("b2b_second_done", {31'd0, done_o}, 32'd1);
        check("b2b_second_result", result_o, 32'd8);
        apply(32'd0, 32'd0, 1'b0, 3'b000, 1'b0);

        // Non-MUL codes and invalid MUL never stall.
        for (int i = 0; i < 3; i++) begin
            apply(32'd9, 32'd9, 1'b1, 3'b000, 1'b0);
            check("nonmul_000_stall", {31'd0, stall_o}, 32'd0);
            apply(32'd9, 32'd9, 1'b1, 3'b101, 1'b0);
            check("nonmul_101_stall", {31'd0, stall_o}, 32'd0);
            apply(32'd9, 32'd9, 1'b0, 3'b100, 1'b0);
            check("invalid_mul_stall", {31'd0, stall_o}, 32'd0);
            check("nonmul_done", {31'd0, done_o}, 32'd0);
        end
        check("nonmul_result_kept", result_o, 32'd8);

        // Reset during BUSY iteration 10: abort, no done pulse.
        apply(32'h8000_0000, 32'h8000_0000, 1'b1, 3'b100, 1'b0);
        check("abort_start", {31'd0, stall_o}, 32'd1);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk_i);
            #2;
            check("abort_busy_stall", {31'd0, stall_o}, 32'd1);
        end
        rst_i = 1'b1;
        #1;
        check("abort_rst_stall", {31'd0, stall_o}, 32'd0);
        check("abort_rst_done", {31'd0, done_o}, 32'd0);
        apply(32'd0, 32'd0, 1'b0, 3'b000, 1'b0);
        rst_i = 1'b0;
        #1;
        check("abort_idle_stall", {31'd0, stall_o}, 32'd0);
        check("abort_idle_done", {31'd0, done_o}, 32'd0);
        check("abort_result", result_o, 32'd0);
        apply(32'd0, 32'd0, 1'b0, 3'b000, 1'b0);
        check("abort_no_done", {31'd0, done_o}, 32'd0);

        // Fresh MUL after the abort.
        apply(32'd2, 32'd2, 1'b1, 3'b100, 1'b0);
        count_stall(n);
        check("post_abort_stall", n, 32'd3);
        check("post_abort_done", {31'd0, done_o}, 32'd1);
        check("post_abort_result", result_o, 32'd4);
        apply(32'd0, 32'd0, 1'b0, 3'b000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Multi-cycle controller and datapath for the EX-stage MUL operation, selected when the ALU control code is 3'b100.
- Detects a MUL in EX and runs an iterative shift-add multiply that produces the low WIDTH bits of the product.
- Holds the pipeline stalled until the product is ready.
- Sits beside the single-cycle ALU; the EX result mux selects result_o when done_o is high.

Parameters:
WIDTH, 32, operand and result width in bits
MUL_CODE, 3'b100, ALU control code that requests a multiply
CNT_W, 5, iteration counter width; must equal clog2(WIDTH)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
valid_i  input  1  EX stage holds a valid instruction
ALUCtrl_i  input  3  ALU control code of the EX instruction
data1_i  input  WIDTH  multiplicand (rs1 after forwarding)
data2_i  input  WIDTH  multiplier (rs2 after forwarding)
hold_i  input  1  external stall from another hazard source; pipeline will not advance this cycle
stall_o  output  1  freeze PC, IF/ID, ID/EX; bubble EX/MEM
done_o  output  1  result_o is valid this cycle; MUL retires from EX
result_o  output  WIDTH  product bits [WIDTH-1:0]

Behaviour:
- States: IDLE, BUSY, DONE.
- Internal registers: mcand (WIDTH), mplier (WIDTH), acc (WIDTH), cnt (CNT_W).
- req = valid_i && (ALUCtrl_i == MUL_CODE).
- Reset (rst_i=1 at edge):
  - state=IDLE; mcand, mplier, acc and cnt = 0.
  - While rst_i is high, stall_o=0 and done_o=0 (outputs forced combinationally).
  - result_o=0 after reset.
  - Reset mid-BUSY or mid-DONE aborts the operation with no done_o pulse.
- IDLE:
  - If req: latch mcand=data1_i, mplier=data2_i, acc=0, cnt=0; go to BUSY.
  - stall_o=req, combinational, in the same cycle, so the MUL stays in EX.
  - Otherwise remain in IDLE with stall_o=0.
- BUSY, one iteration per cycle:
  - If mplier[0], acc += mcand, modulo 2^WIDTH.
  - Then mcand <<= 1; mplier >>= 1; cnt++.
  - Go to DONE when the post-shift mplier == 0 or cnt == WIDTH-1 (early termination).
  - stall_o=1 throughout.
  - data1_i, data2_i, ALUCtrl_i, valid_i and hold_i are ignored.
- DONE:
  - stall_o=0, done_o=1.
  - If hold_i=0: go to IDLE.
  - If hold_i=1: stay in DONE with done_o=1 and result_o stable. The same MUL is still in EX and must not restart.
  - req is ignored in DONE, because the retiring MUL still presents MUL_CODE.
- result_o = acc at all times; it holds the last product in IDLE until the next start.
- Latency:
  - k = index of the highest set bit of data2_i; k=0 when data2_i=0.
  - stall_o is high for k+2 consecutive cycles (the IDLE request cycle plus k+1 BUSY cycles).
  - done_o rises on the next cycle.
  - Minimum stall is 2 cycles; maximum is WIDTH+1 = 33 cycles.
- Back-to-back MULs: the second MUL enters EX in the cycle after DONE (hold_i=0). It is seen in IDLE and starts immediately; there is no idle gap beyond the DONE cycle.
- Signedness: the low WIDTH bits are identical for signed and unsigned operands, so no sign handling is required.
- Non-MUL codes (000, 001, 010, 011, 101, 110) and valid_i=0 never start an operation and never raise stall_o.
- stall_o is combinational from state and req; done_o is decoded from state.

Test Plan:
- 7 x 6: valid_i=1, ALUCtrl_i=3'b100, data1_i=7, data2_i=6 -> stall_o high 4 cycles, then done_o=1 for 1 cycle with result_o=42, then IDLE.
- 0xFFFFFFFF x 0xFFFFFFFF -> stall_o high 33 cycles, then done_o with result_o=0x00000001. Repeat with 0x12345678 x 0 -> stall 2 cycles, result_o=0.
- Hold in DONE: 5 x 3 with hold_i=1 for 3 cycles when done_o rises -> done_o stays 1 for 3 cycles, result_o=15 stable, stall_o=0, no restart even though req is still high. Release hold_i -> IDLE.
- Back-to-back: MUL 3 x 3, then a second MUL 2 x 4 present in the cycle after DONE -> first result 9. Second stall_o rises in that same cycle; 4 stall cycles, result_o=8.
- Non-MUL: ALUCtrl_i=3'b000 and 3'b101 with valid_i=1, plus ALUCtrl_i=3'b100 with valid_i=0 -> stall_o=0 and done_o=0 throughout, state stays IDLE.
- Reset mid-BUSY: 0x80000000 x 0x80000000, assert rst_i at BUSY cycle 10 -> next cycle IDLE, stall_o=0, result_o=0, no done_o. A new MUL 2 x 2 afterward -> result_o=4.
